// File: rtl/mdu_div_pkg.sv
// mdu_div_pkg: shared operand/counter widths and FSM state encoding for the iterative divider
package mdu_div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;
    typedef enum logic [1:0] {
        DIV_FREE = 2'd0,
        DIV_ON   = 2'd1,
        DIV_END  = 2'd2
    } div_state_e;
endpackage

// File: rtl/mdu_div_if.sv
// mdu_div_if: EX<->divider bus; master drives start_i/signed_i/opdata1_i/opdata2_i/annul_i, slave drives result_o/ready_o/stallreq_o
interface mdu_div_if;
    import mdu_div_pkg::*;
    logic                     start_i;
    logic                     signed_i;
    logic [DIV_WIDTH-1:0]     opdata1_i;
    logic [DIV_WIDTH-1:0]     opdata2_i;
    logic                     annul_i;
    logic [2*DIV_WIDTH-1:0]   result_o;
    logic                     ready_o;
    logic                     stallreq_o;
    modport master (
        output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );
    modport slave (
        input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring iteration; in rem/quo/divisor, out rem_n/quo_n
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_n,
    output logic [WIDTH-1:0] quo_n
);
    logic [WIDTH:0] sh;
    logic           ok;
    always_comb begin
        sh    = {rem, quo[WIDTH-1]};
        ok    = sh >= {1'b0, divisor};
        rem_n = ok ? sh[WIDTH-1:0] - divisor : sh[WIDTH-1:0];
        quo_n = {quo[WIDTH-2:0], ok};
    end
endmodule

// File: rtl/mdu_div.sv
// mdu_div: iterative radix-2 DIV/DIVU (HI=rem, LO=quo); ports clk, rst (async high), bus (mdu_div_if.slave)
module mdu_div
    import mdu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input logic      clk,
    input logic      rst,
    mdu_div_if.slave bus
);
    div_state_e         state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0]   rem, quo, dvs, rem_n, quo_n, dvs_n, rem_s, quo_s;
    logic               sign_q, sign_r, sign_q_n, sign_r_n, ready_n, neg1, neg2;
    logic [2*WIDTH-1:0] result_n;
    assign neg1 = bus.signed_i & bus.opdata1_i[WIDTH-1];
    assign neg2 = bus.signed_i & bus.opdata2_i[WIDTH-1];
    assign bus.stallreq_o = bus.start_i & ~bus.ready_o & ~bus.annul_i;
    mdu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .quo     (quo),
        .divisor (dvs),
        .rem_n   (rem_s),
        .quo_n   (quo_s)
    );
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rem_n    = rem;
        quo_n    = quo;
        dvs_n    = dvs;
        sign_q_n = sign_q;
        sign_r_n = sign_r;
        ready_n  = bus.ready_o;
        result_n = bus.result_o;
        if (bus.annul_i) begin
            state_n  = DIV_FREE;
            ready_n  = 1'b0;
            result_n = '0;
        end else begin
            case (state)
                DIV_FREE: begin
                    if (bus.start_i && bus.opdata2_i == '0) begin
                        state_n  = DIV_END;
                        ready_n  = 1'b1;
                        result_n = '0;
                    end else if (bus.start_i) begin
                        state_n  = DIV_ON;
                        cnt_n    = '0;
                        rem_n    = '0;
                        quo_n    = neg1 ? -bus.opdata1_i : bus.opdata1_i;
                        dvs_n    = neg2 ? -bus.opdata2_i : bus.opdata2_i;
                        sign_q_n = neg1 ^ neg2;
                        sign_r_n = neg1;
                    end
                end
                DIV_ON: begin
                    rem_n = rem_s;
                    quo_n = quo_s;
                    cnt_n = cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state_n  = DIV_END;
                        ready_n  = 1'b1;
                        result_n = {sign_r ? -rem_s : rem_s, sign_q ? -quo_s : quo_s};
                    end
                end
                DIV_END: begin
                    if (!bus.start_i) begin
                        state_n  = DIV_FREE;
                        ready_n  = 1'b0;
                        result_n = '0;
                    end
                end
                default: state_n = DIV_FREE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= DIV_FREE;
            cnt          <= '0;
            rem          <= '0;
            quo          <= '0;
            dvs          <= '0;
            sign_q       <= 1'b0;
            sign_r       <= 1'b0;
            bus.ready_o  <= 1'b0;
            bus.result_o <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            rem          <= rem_n;
            quo          <= quo_n;
            dvs          <= dvs_n;
            sign_q       <= sign_q_n;
            sign_r       <= sign_r_n;
            bus.ready_o  <= ready_n;
            bus.result_o <= result_n;
        end
    end
endmodule
